// File: rtl/antirrebote_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default timing constants (50 MHz clock: 20 ms debounce, 2 s long press).
package antirrebote_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } estado_e;

    localparam logic [19:0] DEB_CYC_DEF  = 20'd1000000;
    localparam logic [26:0] LONG_CYC_DEF = 27'd100000000;

endpackage

// File: rtl/antirrebote_pulso_sincronizador.sv
// Two-flop synchronizer bringing the raw button into the clk domain.
module sincronizador (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/antirrebote_pulso.sv
// Push-button debouncer with one-cycle press strobe and optional long-press
// strobe (long-press logic built only when ANTIRREBOTE_LONG_EN is defined).
//
// state       | meaning
// IDLE        | button released and stable
// DEB_PRESS   | button seen high, waiting out the press bounce window
// PRESSED     | press accepted, long-press timer running
// DEB_RELEASE | button seen low, waiting out the release bounce window
module antirrebote_pulso
    import antirrebote_pkg::*;
#(
    parameter int                    BIT_DEB  = 20,
    parameter logic [BIT_DEB-1:0]    DEB_CYC  = DEB_CYC_DEF,
    parameter int                    BIT_LONG = 27,
    parameter logic [BIT_LONG-1:0]   LONG_CYC = LONG_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic pulse,
    output logic long_pulse
);

    // The debounce counter holds the cycles already spent in the window, so
    // the window closes when it reaches DEB_CYC-2 on the last stable cycle.
    localparam logic [BIT_DEB-1:0]  DEB_LAST  = DEB_CYC - BIT_DEB'(2);
    localparam logic [BIT_LONG-1:0] LONG_LAST = LONG_CYC - BIT_LONG'(1);

    if (DEB_CYC < BIT_DEB'(2) || 64'(LONG_CYC) <= 64'(DEB_CYC)) begin : g_cfg_err
        $error("antirrebote_pulso: need DEB_CYC >= 2 and LONG_CYC > DEB_CYC");
    end

    logic               btn_sync;
    estado_e            state_q;
    logic [BIT_DEB-1:0] deb_cnt_q;
    logic               level_q;
    logic               pulse_q;

    sincronizador u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_in),
        .q_o (btn_sync)
    );

`ifdef ANTIRREBOTE_LONG_EN
    logic [BIT_LONG-1:0] long_cnt_q;
    logic                long_done_q;
    logic                long_pulse_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            deb_cnt_q    <= '0;
            level_q      <= 1'b0;
            pulse_q      <= 1'b0;
`ifdef ANTIRREBOTE_LONG_EN
            long_cnt_q   <= '0;
            long_done_q  <= 1'b0;
            long_pulse_q <= 1'b0;
`endif
        end else begin
            pulse_q      <= 1'b0;
`ifdef ANTIRREBOTE_LONG_EN
            long_pulse_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    level_q <= 1'b0;
                    if (btn_sync) begin
                        state_q   <= DEB_PRESS;
                        deb_cnt_q <= '0;
                    end
                end
                DEB_PRESS: begin
                    if (!btn_sync) begin
                        state_q <= IDLE;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q <= PRESSED;
                        pulse_q <= 1'b1;
                        level_q <= 1'b1;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + BIT_DEB'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_sync) begin
                        state_q   <= DEB_RELEASE;
                        deb_cnt_q <= '0;
                    end
`ifdef ANTIRREBOTE_LONG_EN
                    else if (long_cnt_q != LONG_LAST) begin
                        long_cnt_q <= long_cnt_q + BIT_LONG'(1);
                    end else if (!long_done_q) begin
                        long_pulse_q <= 1'b1;
                        long_done_q  <= 1'b1;
                    end
`endif
                end
                DEB_RELEASE: begin
                    // A bounce back to high resumes the press without a new strobe.
                    if (btn_sync) begin
                        state_q <= PRESSED;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q     <= IDLE;
                        level_q     <= 1'b0;
`ifdef ANTIRREBOTE_LONG_EN
                        long_cnt_q  <= '0;
                        long_done_q <= 1'b0;
`endif
                    end else begin
                        deb_cnt_q <= deb_cnt_q + BIT_DEB'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

`ifdef ANTIRREBOTE_LONG_EN
    assign long_pulse = long_pulse_q;
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_antirrebote_pulso.sv
// Scoreboard bench for antirrebote_pulso with DEB_CYC=4, LONG_CYC=10.
module tb_antirrebote_pulso;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic level;
    logic pulse;
    logic long_pulse;

    always #5 clk = ~clk;

`ifdef ANTIRREBOTE_LONG_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // expected {level, pulse, long_pulse} per edge, with the btn_in for that edge
    logic [2:0] sb[$];
    logic       stim[$];

    antirrebote_pulso #(
        .BIT_DEB  (4),
        .DEB_CYC  (4'd4),
        .BIT_LONG (5),
        .LONG_CYC (5'd10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .level      (level),
        .pulse      (pulse),
        .long_pulse (long_pulse)
    );

    task automatic push(input logic b, input logic lvl, input logic pls, input logic lng);
        stim.push_back(b);
        sb.push_back({lvl, pls, lng});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        btn_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst    = 1'b1;
        btn_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({level, pulse, long_pulse} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold edge %0d: got lvl/pls/lng=%b want 000",
                         k, {level, pulse, long_pulse});
            end
        end
        do_reset();
        #1;
        checks++;
        if ({level, pulse, long_pulse} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got lvl/pls/lng=%b want 000", {level, pulse, long_pulse});
        end
    endtask

    // held press (30 edges) then release; also the long-press point
    task automatic test_press_long();
        logic [2:0] e;
        logic b;
        int k = 0;
        do_reset();
        for (int i = 1; i <= 40; i++)
            push(i <= 30, (i >= 6) && (i < 36), i == 6, LONG_EN && (i == 16));
        while (sb.size() > 0) begin
            b = stim.pop_front();
            e = sb.pop_front();
            k++;
            @(negedge clk);
            btn_in = b;
            @(posedge clk);
            #1;
            checks++;
            if ({level, pulse, long_pulse} !== e) begin
                errors++;
                $display("FAIL press_long edge %0d: got lvl/pls/lng=%b want %b",
                         k, {level, pulse, long_pulse}, e);
            end
        end
    endtask

    // second press without reset: long counter and long_done must be cleared
    task automatic test_long_rearm();
        logic [2:0] e;
        logic b;
        int k = 0;
        for (int i = 1; i <= 30; i++)
            push(i <= 20, (i >= 6) && (i < 26), i == 6, LONG_EN && (i == 16));
        while (sb.size() > 0) begin
            b = stim.pop_front();
            e = sb.pop_front();
            k++;
            @(negedge clk);
            btn_in = b;
            @(posedge clk);
            #1;
            checks++;
            if ({level, pulse, long_pulse} !== e) begin
                errors++;
                $display("FAIL long_rearm edge %0d: got lvl/pls/lng=%b want %b",
                         k, {level, pulse, long_pulse}, e);
            end
        end
    endtask

    // 3-cycle glitch rejected, then a normal press with exact latency
    task automatic test_short_glitch();
        logic [2:0] e;
        logic b;
        int k = 0;
        do_reset();
        for (int i = 1; i <= 32; i++)
            push((i <= 3) || (i >= 13 && i <= 22), (i >= 18) && (i < 28), i == 18, 1'b0);
        while (sb.size() > 0) begin
            b = stim.pop_front();
            e = sb.pop_front();
            k++;
            @(negedge clk);
            btn_in = b;
            @(posedge clk);
            #1;
            checks++;
            if ({level, pulse, long_pulse} !== e) begin
                errors++;
                $display("FAIL short_glitch edge %0d: got lvl/pls/lng=%b want %b",
                         k, {level, pulse, long_pulse}, e);
            end
        end
    endtask

    // 2-cycle release bounce: no second pulse, long timer paused not re-armed
    task automatic test_release_bounce();
        logic [2:0] e;
        logic b;
        int k = 0;
        do_reset();
        for (int i = 1; i <= 35; i++)
            push((i <= 10) || (i >= 13 && i <= 25), (i >= 6) && (i < 31), i == 6,
                 LONG_EN && (i == 19));
        while (sb.size() > 0) begin
            b = stim.pop_front();
            e = sb.pop_front();
            k++;
            @(negedge clk);
            btn_in = b;
            @(posedge clk);
            #1;
            checks++;
            if ({level, pulse, long_pulse} !== e) begin
                errors++;
                $display("FAIL release_bounce edge %0d: got lvl/pls/lng=%b want %b",
                         k, {level, pulse, long_pulse}, e);
            end
        end
    endtask

    // reset asserted for edge 8 while held: async clear, then one fresh pulse
    task automatic test_reset_mid_press();
        logic [2:0] e;
        logic b;
        int k = 0;
        do_reset();
        for (int i = 1; i <= 20; i++)
            push(1'b1, ((i >= 6) && (i < 8)) || (i >= 14), (i == 6) || (i == 14), 1'b0);
        while (sb.size() > 0) begin
            b = stim.pop_front();
            e = sb.pop_front();
            k++;
            @(negedge clk);
            btn_in = b;
            rst    = (k == 8);
            if (k == 8) begin
                #1;
                checks++;
                if ({level, pulse, long_pulse} !== 3'b000) begin
                    errors++;
                    $display("FAIL reset_async: got lvl/pls/lng=%b want 000",
                             {level, pulse, long_pulse});
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if ({level, pulse, long_pulse} !== e) begin
                errors++;
                $display("FAIL reset_mid_press edge %0d: got lvl/pls/lng=%b want %b",
                         k, {level, pulse, long_pulse}, e);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 1'b0;
        test_reset();
        test_press_long();
        test_long_rearm();
        test_short_glitch();
        test_release_bounce();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
